// File: rtl/dmem_responder.sv
// Multi-cycle word data memory with valid/ready request and response channels.
// Self-initialises mem[i] = i after reset. Optional alignment checking: DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LCW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     init_cnt_q, init_cnt_d;
  logic [LCW-1:0]  lat_cnt_q, lat_cnt_d;
  logic            rsel_q, rsel_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_rd_q;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_re;
  logic            misaligned;
  logic            unused_addr_bits;

  assign req_idx          = req_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |req_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    rsel_d     = rsel_q;
    err_d      = err_q;
    mem_be     = 4'h0;
    mem_waddr  = req_idx;
    mem_wdata  = req_wdata;
    mem_re     = 1'b0;
    case (state_q)
      INIT: begin
        mem_be     = 4'hF;
        mem_waddr  = init_cnt_q[AW-1:0];
        mem_wdata  = 32'(init_cnt_q);
        init_cnt_d = init_cnt_q + (AW+1)'(1);
        if (init_cnt_q == (AW+1)'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (req_valid && !rst) begin
          // Load data is captured now, so a following store cannot disturb it.
          err_d  = misaligned;
          rsel_d = !req_write && !misaligned;
          mem_re = !req_write && !misaligned;
          if (req_write && !misaligned) begin
            mem_be = req_wstrb;
          end
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            lat_cnt_d = LCW'(LATENCY - 1);
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q <= LCW'(1)) begin
          lat_cnt_d = '0;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rsel_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      rsel_q     <= rsel_d;
      err_q      <= err_d;
    end
  end

  // Array kept free of reset so it maps onto block RAM with byte-write enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) begin
      mem_rd_q <= mem[req_idx];
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rsel_q ? mem_rd_q : 32'h0;
  assign resp_err   = err_q;
  assign init_done  = (state_q != INIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table driven through a response scoreboard,
// plus hand sequences for init timing, backpressure, abort-by-reset and misaligned stores.
module tb_dmem_responder;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[13];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic        MIS_ERR   = 1'b1;
  localparam logic [31:0] MIS_WORD8 = 32'h0000_0008;
`else
  localparam logic        MIS_ERR   = 1'b0;
  localparam logic [31:0] MIS_WORD8 = 32'hAAAA_AAAA;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Holds reset, checks reset outputs, releases it and measures init duration.
  task automatic do_reset();
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata,      32'h0);
    chk("rst_resp_err",   32'(resp_err),   32'h0);
    chk("rst_init_done",  32'(init_done),  32'h0);
    rst = 1'b0;
    n = 0;
    // n counts edges from the first one that samples rst low (edge R counts as 1).
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 1000);
    chk("init_latency", n, DEPTH);
    chk("init_req_ready", 32'(req_ready), 32'h1);
    $display("reset: init_done after %0d edges", n);
  endtask

  // Drives one request and returns just after the acceptance edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee,
                       input bit push);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0, expected 1");
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    if (push) sb_q.push_back('{er, ee});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hx;
  endtask

  // Waits for the response, checks latency/data, optionally stalls, then completes the handshake.
  task automatic await_resp(input int stall, input string tag);
    int   edges = 0;
    exp_t e;
    @(negedge clk);
    while (!resp_valid && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    // Response is first visible after LATENCY-1 further edges following acceptance.
    chk({tag, "_latency"}, edges, LATENCY - 1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_scoreboard_empty: got response, expected none", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
    chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'h0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(resp_valid), 32'h1);
      chk({tag, "_stall_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_stall_req_ready"}, 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(resp_valid), 32'h0);
    chk({tag, "_req_ready_back"}, 32'(req_ready), 32'h1);
    $display("%s: rdata=0x%08h err=%0b latency_edges=%0d", tag, resp_rdata, resp_err, edges);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee,
                     input int stall, input string tag);
    resp_ready = (stall == 0);
    issue(w, a, d, s, er, ee, 1'b1);
    await_resp(stall, tag);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_wstrb  = 4'h0;
    resp_ready = 1'b1;

    vecs[0]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h0000_0005, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'h0000_007F, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hDEADBEEF,  4'hF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0220, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0024, 32'h12340000,  4'hC, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h1234_0009, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0030, 32'hFFFFFFFF,  4'h0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h0000_000C, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_01FC, 32'h000000AA,  4'h1, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_01FC, 32'h0,         4'h0, 32'h0000_00AA, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0014, 32'h0,         4'h0, 32'h0000_0005, 1'b0};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
          vecs[i].exp_rdata, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: response must hold for 5 stalled cycles.
    txn(1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0000_0003, 1'b0, 5, "backpressure");

    // Reset while the store is in WAIT: no response may appear.
    resp_ready = 1'b1;
    issue(1'b1, 32'h0000_0008, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    $display("abort: responses seen during reset=%0d", seen);
    do_reset();

    txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0000_0002, 1'b0, 0, "after_abort");
    txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_0008, 1'b0, 0, "reinit_word8");

    txn(1'b1, 32'h0000_0022, 32'hAAAAAAAA, 4'hF, 32'h0, MIS_ERR, 0, "misaligned_store");
    txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, MIS_WORD8, 1'b0, 0, "misaligned_check");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MIPS/RISC-V datapath. It serves word load/store requests from the core over a valid/ready request channel and a valid/ready response channel, with a fixed configurable access latency. It replaces the combinational `memory` stage when the core runs in multi-cycle mode. After reset it self-initialises its array so that word i holds the value i.

## Interface
- DEPTH, 128, number of 32-bit words; power of two, ≥ 2
- LATENCY, 2, cycles from request acceptance to first `resp_valid`; ≥ 1
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address; word index = req_addr[log2(DEPTH)+1:2], upper bits ignored (aliasing)
- req_wdata  input  32  store data
- req_wstrb  input  4  byte enables for a store; bit k enables byte lane [8k+7:8k]
- resp_valid  output  1  response present
- resp_ready  input  1  core accepts the response
- resp_rdata  output  32  load data; 0 for a store response
- resp_err  output  1  error flag (see Configuration)
- init_done  output  1  high once self-initialisation has completed

## Operation
- FSM states are INIT, IDLE, WAIT, and RESP.
- INIT: entered on reset.
  - Writes mem[i] = i, one word per cycle, for i = 0 … DEPTH-1. This takes DEPTH cycles.
  - Moves to IDLE after writing word DEPTH-1. `init_done` rises on entry to IDLE and stays high until the next reset.
- IDLE: `req_ready` = 1. When `req_valid` && `req_ready` (acceptance):
  - A load latches mem[index] into the read register.
  - A store writes the enabled bytes of `req_wdata` into mem[index] at that edge.
  - The latency counter is loaded with LATENCY-1. The FSM goes to WAIT, or straight to RESP if LATENCY = 1.
- WAIT: the counter decrements once per cycle. At 0 the FSM moves to RESP.
- RESP: `resp_valid` = 1.
  - `resp_rdata` and `resp_err` are held stable until `resp_ready`.
  - On the `resp_valid` && `resp_ready` edge the FSM returns to IDLE and `resp_valid` drops.
- `req_ready` is 0 in every state except IDLE. Only one request is ever outstanding.
- Store with `req_wstrb` = 0: no array change, but a normal response is still returned.
- Load followed immediately by a store to the same word: the load returns the pre-store value, because data is latched at acceptance.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset values: `req_ready` 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `init_done` 0. The FSM is in INIT with the init counter at 0.
- Reset deasserts at edge R. `init_done` and `req_ready` go high in cycle R+DEPTH.
- Request accepted at edge T. `resp_valid` is first high in cycle T+LATENCY.
- Response accepted at edge U. `req_ready` is high in cycle U+1.
- Minimum request-to-request spacing is LATENCY+1 cycles.
- Reset asserted in any state, including mid-WAIT, mid-RESP, or mid-INIT:
  - The pending request is discarded with no response.
  - All outputs return to reset values at the next edge.
  - INIT restarts from word 0.
  - A store already accepted stays written, but is then overwritten by initialisation.
- The latency counter is sized ceil(log2(LATENCY+1)) bits. The init counter is log2(DEPTH)+1 bits and must not wrap before the transition to IDLE.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - An accepted request with `req_addr[1:0]` ≠ 0 is not performed: no write, and `resp_rdata` = 0.
  - It still gets a response after LATENCY cycles, with `resp_err` = 1.
  - Aligned requests return `resp_err` = 0.
- DMEM_ALIGN_CHECK_EN undefined:
  - `req_addr[1:0]` is ignored and the access goes to the containing word.
  - `resp_err` is tied to 0.

## Test plan
- Reset, then release → `init_done` = 1 exactly DEPTH (128) cycles later. Load 0x14 → `resp_rdata` = 0x00000005, with `resp_valid` at acceptance+2.
- Store 0xDEADBEEF to 0x20 with `wstrb` 0xF, then load 0x20 → 0xDEADBEEF. Then load 0x220 (alias, DEPTH 128) → 0xDEADBEEF.
- Store 0x12340000 to 0x24 with `wstrb` 0xC, then load 0x24 → 0x12340009.
- Backpressure: during a load of 0x0C, hold `resp_ready` low for 5 cycles → `resp_valid` = 1 and `resp_rdata` = 0x3 stable throughout, `req_ready` = 0. After the handshake, `req_ready` = 1 the next cycle.
- Assert `rst` in WAIT after accepting a store of 0xFFFFFFFF to 0x08 → no response. After re-init, load 0x08 → 0x00000002.
- Store to 0x22 with data 0xAAAAAAAA and `wstrb` 0xF:
  - With DMEM_ALIGN_CHECK_EN: `resp_err` = 1, and a later load of 0x20 → 0x00000008.
  - Without it: `resp_err` = 0, and a load of 0x20 → 0xAAAAAAAA.
